led_pattern_sequencer: RTL and testbench

Controller for the 8-switch to 8-LED bank. It decides what the LEDs show: the live switch values, a walking one, a binary count, or a blinking copy of the switches. It sits between the raw board switches and buttons and the LED pins, and replaces the direct switch-to-LED wiring in the top level. It contains input synchronizers, button edge detection, a tick prescaler and a 4-state mode FSM.

---
 rtl/led_pattern_sequencer.sv | 120 ++++++++++++
 tb/tb_led_pattern_sequencer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_sequencer.sv
// LED bank controller: shows live switches, a walking one, a binary count or blinking switches,
// selected by a debounced-by-sync mode button, frozen by a hold button, paced by a tick prescaler.
//
// state | meaning
// PASS  | led follows synchronized switches
// SHIFT | walking one, rotates left once per tick
// COUNT | 8-bit binary count, +1 per tick
// BLINK | led alternates between switches and 00 per tick
module led_pattern_sequencer #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] sw,
  input  logic       btn_mode,
  input  logic       btn_hold,
  output logic [7:0] led,
  output logic [1:0] mode,
  output logic       tick
);

  localparam int            CW      = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_TOP = CW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    PASS  = 2'd0,
    SHIFT = 2'd1,
    COUNT = 2'd2,
    BLINK = 2'd3
  } mode_e;

  logic [7:0]    sw_s1_q, sw_s2_q;
  logic          mode_s1_q, mode_s2_q;
  logic          hold_s1_q, hold_s2_q;
  logic          prev_q;
  logic [CW-1:0] cnt_q;
  logic          tick_q;
  mode_e         state_q, state_d;
  logic [7:0]    pat_q, pat_d;
  logic          phase_q, phase_d;
  logic [7:0]    led_q, led_d;
  logic          mode_edge;
  logic          advance;

  assign mode_edge = mode_s2_q & ~prev_q;
  // a mode change or hold swallows the tick for pattern purposes
  assign advance   = tick_q & ~hold_s2_q & ~mode_edge;

  always_ff @(posedge clk) begin
    if (rst) begin
      sw_s1_q   <= 8'h00;
      sw_s2_q   <= 8'h00;
      mode_s1_q <= 1'b0;
      mode_s2_q <= 1'b0;
      hold_s1_q <= 1'b0;
      hold_s2_q <= 1'b0;
      prev_q    <= 1'b0;
      cnt_q     <= '0;
      tick_q    <= 1'b0;
    end else begin
      sw_s1_q   <= sw;
      sw_s2_q   <= sw_s1_q;
      mode_s1_q <= btn_mode;
      mode_s2_q <= mode_s1_q;
      hold_s1_q <= btn_hold;
      hold_s2_q <= hold_s1_q;
      prev_q    <= mode_s2_q;
      cnt_q     <= (cnt_q == CNT_TOP) ? '0 : cnt_q + CW'(1);
      tick_q    <= (cnt_q == CNT_TOP);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= PASS;
      pat_q   <= 8'h00;
      phase_q <= 1'b0;
      led_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      phase_q <= phase_d;
      led_q   <= led_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    phase_d = phase_q;
    led_d   = 8'h00;

    if (mode_edge) begin
      case (state_q)
        PASS:  begin state_d = SHIFT; pat_d = 8'h01; end
        SHIFT: begin state_d = COUNT; pat_d = 8'h00; end
        COUNT: begin state_d = BLINK; phase_d = 1'b0; end
        default: state_d = PASS;
      endcase
    end else if (advance) begin
      case (state_q)
        SHIFT:   pat_d   = {pat_q[6:0], pat_q[7]};
        COUNT:   pat_d   = pat_q + 8'd1;
        BLINK:   phase_d = ~phase_q;
        default: pat_d   = pat_q;
      endcase
    end

    case (state_q)
      PASS:         led_d = sw_s2_q;
      SHIFT, COUNT: led_d = pat_q;
      default:      led_d = phase_q ? sw_s2_q : 8'h00;
    endcase
  end

  assign led  = led_q;
  assign mode = state_q;
  assign tick = tick_q;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Scoreboard bench for led_pattern_sequencer with TICK_DIV = 4: stimulus queues expected
// (cycle, signal, value) entries; a negedge monitor compares whichever entries are due.
module tb_led_pattern_sequencer;

  logic       clk;
  logic       rst;
  logic [7:0] sw;
  logic       btn_mode;
  logic       btn_hold;
  logic [7:0] led;
  logic [1:0] mode;
  logic       tick;

  led_pattern_sequencer #(.TICK_DIV(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .sw       (sw),
    .btn_mode (btn_mode),
    .btn_hold (btn_hold),
    .led      (led),
    .mode     (mode),
    .tick     (tick)
  );

  localparam int K_LED  = 0;
  localparam int K_MODE = 1;
  localparam int K_TICK = 2;

  typedef struct {
    int         cyc;
    int         kind;
    logic [7:0] val;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // cyc = number of rising edges seen so far
  always @(posedge clk) cyc <= cyc + 1;

  function automatic string kname(input int k);
    case (k)
      K_LED:   return "led";
      K_MODE:  return "mode";
      default: return "tick";
    endcase
  endfunction

  always @(negedge clk) begin
    logic [7:0] act;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc <= cyc) begin
        case (sb[i].kind)
          K_LED:   act = led;
          K_MODE:  act = {6'b0, mode};
          default: act = {7'b0, tick};
        endcase
        checks++;
        if (act !== sb[i].val || sb[i].cyc != cyc) begin
          errors++;
          $display("FAIL %s@%0d (seen at %0d): got %02h expected %02h",
                   kname(sb[i].kind), sb[i].cyc, cyc, act, sb[i].val);
        end
        sb.delete(i);
      end
    end
  end

  task automatic expect_at(input int c, input int k, input logic [7:0] v);
    exp_t e;
    e.cyc  = c;
    e.kind = k;
    e.val  = v;
    sb.push_back(e);
  endtask

  // returns 1 time unit after rising edge number c
  task automatic wait_cyc(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst      = 1'b1;
    sw       = 8'hA5;
    btn_mode = 1'b0;
    btn_hold = 1'b0;

    // reset held for edges 1..3
    for (int c = 1; c <= 3; c++) begin
      expect_at(c, K_LED, 8'h00);
      expect_at(c, K_MODE, 8'h00);
      expect_at(c, K_TICK, 8'h00);
    end
    expect_at(5, K_LED, 8'h00);
    expect_at(6, K_LED, 8'hA5);
    // first non-reset edge is 4, so ticks follow edges 7, 11, 15, ...
    for (int c = 4; c <= 23; c++)
      expect_at(c, K_TICK, (c >= 7 && (c - 3) % 4 == 0) ? 8'h01 : 8'h00);
    wait_cyc(3);
    rst = 1'b0;

    // PASS -> SHIFT, then walk through a full rotation
    expect_at(26, K_MODE, 8'h00);
    expect_at(27, K_MODE, 8'h01);
    expect_at(28, K_LED, 8'h01);
    expect_at(29, K_LED, 8'h02);
    expect_at(33, K_LED, 8'h04);
    expect_at(37, K_LED, 8'h08);
    expect_at(41, K_LED, 8'h10);
    expect_at(45, K_LED, 8'h20);
    expect_at(49, K_LED, 8'h40);
    expect_at(53, K_LED, 8'h80);
    expect_at(57, K_LED, 8'h01);
    expect_at(65, K_LED, 8'h04);
    wait_cyc(24);
    btn_mode = 1'b1;
    wait_cyc(27);
    btn_mode = 1'b0;

    // hold for 12 cycles at led = 04
    expect_at(69, K_LED, 8'h04);
    expect_at(73, K_LED, 8'h04);
    expect_at(77, K_LED, 8'h04);
    expect_at(80, K_LED, 8'h04);
    expect_at(81, K_LED, 8'h08);
    wait_cyc(65);
    btn_hold = 1'b1;
    wait_cyc(77);
    btn_hold = 1'b0;

    // mode pulse during hold: SHIFT -> COUNT, count frozen until hold releases
    expect_at(84, K_MODE, 8'h01);
    expect_at(85, K_LED, 8'h08);
    expect_at(85, K_MODE, 8'h02);
    expect_at(86, K_LED, 8'h00);
    expect_at(93, K_LED, 8'h00);
    expect_at(96, K_LED, 8'h00);
    expect_at(97, K_LED, 8'h01);
    expect_at(101, K_LED, 8'h02);
    wait_cyc(81);
    btn_hold = 1'b1;
    wait_cyc(82);
    btn_mode = 1'b1;
    wait_cyc(85);
    btn_mode = 1'b0;
    wait_cyc(93);
    btn_hold = 1'b0;

    // count through 255 ticks to FF, wrap to 00, on to 05
    expect_at(1109, K_LED, 8'hFE);
    expect_at(1113, K_LED, 8'hFF);
    expect_at(1117, K_LED, 8'h00);
    expect_at(1137, K_LED, 8'h05);
    wait_cyc(1100);

    // mode edge lands on the same edge as a tick: COUNT -> BLINK, phase stays 0
    expect_at(1139, K_TICK, 8'h01);
    expect_at(1140, K_MODE, 8'h03);
    expect_at(1140, K_LED, 8'h05);
    expect_at(1141, K_LED, 8'h00);
    expect_at(1144, K_LED, 8'h00);
    expect_at(1145, K_LED, 8'h3C);
    expect_at(1149, K_LED, 8'h00);
    expect_at(1153, K_LED, 8'h3C);
    expect_at(1156, K_LED, 8'h5A);
    expect_at(1157, K_LED, 8'h00);
    expect_at(1160, K_LED, 8'h00);
    wait_cyc(1137);
    btn_mode = 1'b1;
    wait_cyc(1140);
    btn_mode = 1'b0;
    wait_cyc(1141);
    sw = 8'h3C;
    wait_cyc(1153);
    sw = 8'h5A;

    // one-cycle reset in BLINK with phase = 1
    expect_at(1161, K_LED, 8'h00);
    expect_at(1161, K_MODE, 8'h00);
    expect_at(1161, K_TICK, 8'h00);
    expect_at(1162, K_LED, 8'h00);
    expect_at(1163, K_LED, 8'h00);
    expect_at(1164, K_LED, 8'h5A);
    expect_at(1164, K_TICK, 8'h00);
    expect_at(1165, K_TICK, 8'h01);
    expect_at(1166, K_TICK, 8'h00);
    wait_cyc(1160);
    rst = 1'b1;
    wait_cyc(1161);
    rst = 1'b0;

    // btn_mode held across reset gives exactly one advance
    expect_at(1172, K_MODE, 8'h00);
    expect_at(1174, K_MODE, 8'h00);
    expect_at(1175, K_MODE, 8'h01);
    expect_at(1176, K_LED, 8'h01);
    expect_at(1185, K_MODE, 8'h01);
    wait_cyc(1170);
    rst      = 1'b1;
    btn_mode = 1'b1;
    wait_cyc(1172);
    rst = 1'b0;
    wait_cyc(1180);
    btn_mode = 1'b0;

    wait_cyc(1190);
    if (sb.size() != 0) begin
      errors += sb.size();
      $display("FAIL pending: %0d expectations never checked, expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
